// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, data-first with a starvation limit.
// Define ARB_PERF_CNT_EN to add perf_if_cnt/perf_d_cnt/perf_stall_cnt counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_d_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
  logic [1:0]        state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic              done;
  always_comb begin
    if_gnt      = state_q == IDLE && if_req && (!d_req || streak_q == LIMIT);
    d_gnt       = state_q == IDLE && d_req && !if_gnt;
    done        = state_q != IDLE && mem_ready;
    state_d     = if_gnt ? BUSY_I : d_gnt ? BUSY_D : done ? IDLE : state_q;
    // streak only grows while a fetch is actually being passed over
    streak_d    = if_gnt ? 4'd0 :
                  d_gnt  ? (if_req ? (streak_q == LIMIT ? LIMIT : streak_q + 4'd1) : 4'd0) :
                  streak_q;
    mem_req_d   = if_gnt || d_gnt || (mem_req_q && !done);
    mem_we_d    = d_gnt ? d_we : if_gnt ? 1'b0 : mem_we_q;
    mem_addr_d  = d_gnt ? d_addr : if_gnt ? if_addr : mem_addr_q;
    mem_wdata_d = d_gnt ? d_wdata : mem_wdata_q;
    if_valid_d  = done && state_q == BUSY_I;
    d_valid_d   = done && state_q == BUSY_D;
    if_rdata_d  = if_valid_d ? mem_rdata : if_rdata_q;
    d_rdata_d   = (d_valid_d && !mem_we_q) ? mem_rdata : d_rdata_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d, perf_d_q, perf_d_d, perf_stall_q, perf_stall_d;
  always_comb begin
    perf_if_d    = perf_if_q + {31'd0, if_gnt};
    perf_d_d     = perf_d_q + {31'd0, d_gnt};
    perf_stall_d = perf_stall_q + {31'd0, if_req && !if_gnt};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_q    <= '0;
      perf_d_q     <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_if_q    <= perf_if_d;
      perf_d_q     <= perf_d_d;
      perf_stall_q <= perf_stall_d;
    end
  end
  assign perf_if_cnt    = perf_if_q;
  assign perf_d_cnt     = perf_d_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single transactions plus hand-written arbitration, busy-hold and reset sequences.
module tb_mem_port_arbiter;
  logic        clk, reset;
  logic        if_req, if_gnt, if_valid, d_req, d_we, d_gnt, d_valid;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt, perf_d_cnt, perf_stall_cnt;
`endif
  int total = 0;
  int bad = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_cnt(perf_if_cnt), .perf_d_cnt(perf_d_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_we;
    int          dly;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    bit isd = v.kind != 2'd0;
    if_req = !isd; if_addr = v.addr;
    d_req = isd; d_we = v.kind == 2'd2; d_addr = v.addr; d_wdata = v.wdata;
    mem_rdata = v.rdata; mem_ready = 1'b0;
    @(negedge clk);
    check("if_gnt", if_gnt, !isd);
    check("d_gnt", d_gnt, isd);
    step();
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i <= v.dly; i++) begin
      mem_ready = i == v.dly;
      @(negedge clk);
      check("mem_req", mem_req, 1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", mem_we, v.exp_we);
      if (v.exp_we) check("mem_wdata", mem_wdata, v.wdata);
      check("busy_valid", if_valid | d_valid, 0);
      step();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("if_valid", if_valid, !isd);
    check("d_valid", d_valid, isd);
    check("rdata", isd ? d_rdata : if_rdata, v.exp_rdata);
    check("mem_req_done", mem_req, 0);
    step();
    @(negedge clk);
    check("valid_pulse", if_valid | d_valid, 0);
    step();
  endtask

  initial begin
    logic gs[10];
    logic exp_seq[10];
    logic both, seen;
    int n;
    vecs = '{
      '{2'd0, 32'h10, 32'h0,        32'hCAFE0001, 32'hCAFE0001, 1'b0, 0},
      '{2'd1, 32'h80, 32'h0,        32'h12345678, 32'h12345678, 1'b0, 1},
      '{2'd2, 32'h40, 32'hDEADBEEF, 32'h55555555, 32'h12345678, 1'b1, 3},
      '{2'd0, 32'h14, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2},
      '{2'd1, 32'h84, 32'h0,        32'h00000000, 32'h00000000, 1'b0, 0},
      '{2'd2, 32'h44, 32'h1,        32'hFFFFFFFF, 32'h00000000, 1'b1, 0}
    };
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b0; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_valids", {if_valid, d_valid}, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run(vecs[i]);

    if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h100; d_addr = 32'h200; mem_ready = 1;
    n = 0; both = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both = 1;
      if (if_gnt || d_gnt) begin
        gs[n] = d_gnt;
        n++;
      end
      step();
    end
    if_req = 0; d_req = 0;
    check("starve_grants", n, 10);
    check("both_gnt", both, 0);
    for (int i = 0; i < 10; i++) check($sformatf("grant_seq[%0d]", i), gs[i], exp_seq[i]);
    repeat (3) step();
    mem_ready = 0;

    d_req = 1; d_we = 0; d_addr = 32'h80; mem_rdata = 32'h12345678;
    @(negedge clk);
    check("busyd_d_gnt", d_gnt, 1);
    step();
    d_req = 0; if_req = 1; if_addr = 32'h20;
    for (int i = 0; i <= 2; i++) begin
      mem_ready = i == 2;
      @(negedge clk);
      check("busyd_if_gnt", if_gnt, 0);
      step();
    end
    mem_ready = 0;
    @(negedge clk);
    check("busyd_d_valid", d_valid, 1);
    check("busyd_d_rdata", d_rdata, 32'h12345678);
    check("busyd_if_gnt_idle", if_gnt, 1);
    step();
    if_req = 0; mem_ready = 1;
    @(negedge clk);
    check("busyd_fetch_addr", mem_addr, 32'h20);
    check("busyd_fetch_we", mem_we, 0);
    step();
    mem_ready = 0;
    @(negedge clk);
    check("busyd_if_valid", if_valid, 1);
    step();

    if_req = 1; if_addr = 32'h30; mem_ready = 0;
    @(negedge clk);
    check("rstmid_gnt", if_gnt, 1);
    step();
    if_req = 0;
    @(negedge clk);
    check("rstmid_busy", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    check("rstmid_rdata", if_rdata | d_rdata, 0);
    step();
    reset = 1'b1; mem_ready = 1; seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_valid || d_valid || mem_req) seen = 1;
      step();
    end
    check("rstmid_no_valid", seen, 0);
    if_req = 1;
    @(negedge clk);
    check("rstmid_idle_gnt", if_gnt, 1);
    step();
    if_req = 0;
    repeat (3) step();
    mem_ready = 0;

`ifdef ARB_PERF_CNT_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    run(vecs[0]);
    run(vecs[3]);
    run(vecs[1]);
    if_req = 1; if_addr = 32'h50; d_req = 1; d_we = 0; d_addr = 32'h90; mem_ready = 0;
    @(negedge clk);
    check("perf_d_first", d_gnt, 1);
    step();
    d_req = 0; mem_ready = 1;
    step();
    mem_ready = 0;
    @(negedge clk);
    check("perf_if_late_gnt", if_gnt, 1);
    step();
    if_req = 0; mem_ready = 1;
    step();
    mem_ready = 0;
    repeat (2) step();
    check("perf_if_cnt", perf_if_cnt, 3);
    check("perf_d_cnt", perf_d_cnt, 2);
    check("perf_stall_cnt", perf_stall_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
